// File: rtl/fir_pkg.sv
// Shared types, default sizes and address helper for the FIR sequencer.
package fir_pkg;

  localparam int NUM_TAPS_DEF = 11;
  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int LEN_W_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_X,
    MAC,
    DRAIN,
    OUT,
    DONE_ST
  } state_e;

  // (ptr - k) mod n for 0 <= ptr, k < n; avoids a real divider.
  function automatic logic [31:0] circ_sub(input logic [31:0] ptr,
                                           input logic [31:0] k,
                                           input logic [31:0] n);
    return (ptr >= k) ? (ptr - k) : (ptr + n - k);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate, wrapping at DATA_W, with synchronous clear.
// sum_o is the value the accumulator takes at the coming edge, so the
// final tap's contribution can be registered straight into the output.
module fir_mac #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] prod;

  // Low DATA_W bits of the signed product; upper bits are discarded.
  assign prod = DATA_W'($signed(a_i) * $signed(b_i));

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = acc_d;

endmodule

// File: rtl/fir_seq.sv
// Sequencer for the single-MAC FIR engine: zeroes the circular data RAM,
// accepts one sample per AXI-Stream beat, runs NUM_TAPS taps through the
// MAC and emits y[n] on the AXI-Stream master.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ap_start, ap_idle high
// INIT    | writing zeros to data RAM addresses 0..NUM_TAPS-1
// WAIT_X  | ss_tready high, waiting for the next input sample
// MAC     | issuing tap / data RAM reads for k = 0..NUM_TAPS-1
// DRAIN   | letting the 2-deep read/accumulate pipeline empty
// OUT     | y[n] presented, waiting for sm_tready
// DONE_ST | raising ap_done, back to IDLE
module fir_seq
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              ap_start,
  input  logic [LEN_W-1:0]  data_length,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              tlast_err,
  input  logic              ss_tvalid,
  output logic              ss_tready,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              sm_tvalid,
  input  logic              sm_tready,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  output logic [ADDR_W-1:0] tap_addr,
  input  logic [DATA_W-1:0] tap_rdata,
  output logic              dat_we,
  output logic [ADDR_W-1:0] dat_addr,
  output logic [DATA_W-1:0] dat_wdata,
  input  logic [DATA_W-1:0] dat_rdata
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  state_e            state_q;
  logic              ap_idle_q;
  logic              ap_done_q;
  logic              tlast_err_q;
  logic              ss_tready_q;
  logic              sm_tvalid_q;
  logic              sm_tlast_q;
  logic [DATA_W-1:0] sm_tdata_q;
  logic [ADDR_W-1:0] tap_addr_q;
  logic              dat_we_q;
  logic [ADDR_W-1:0] dat_addr_q;
  logic [DATA_W-1:0] dat_wdata_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] k_q;
  // iss_q: a read address is on the RAM bus; rd_vld_q: its data is back.
  logic              iss_q;
  logic              rd_vld_q;

  logic              ss_hs;
  logic              is_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] mac_sum;

  assign ss_hs   = (state_q == WAIT_X) && ss_tvalid && ss_tready_q;
  assign is_last = (count_q == len_q - LEN_W'(1));
  assign rd_addr = ADDR_W'(circ_sub(32'(wr_ptr_q), 32'(k_q), 32'(NUM_TAPS)));

  fir_mac #(.DATA_W(DATA_W)) u_mac (
    .clk_i   (axis_clk),
    .rst_n_i (axis_rst_n),
    .clr_i   (ss_hs),
    .en_i    (rd_vld_q),
    .a_i     (tap_rdata),
    .b_i     (dat_rdata),
    .sum_o   (mac_sum)
  );

  // Control FSM with all externally visible outputs registered.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      ap_idle_q   <= 1'b1;
      ap_done_q   <= 1'b0;
      tlast_err_q <= 1'b0;
      ss_tready_q <= 1'b0;
      sm_tvalid_q <= 1'b0;
      sm_tlast_q  <= 1'b0;
      sm_tdata_q  <= '0;
      tap_addr_q  <= '0;
      dat_we_q    <= 1'b0;
      dat_addr_q  <= '0;
      dat_wdata_q <= '0;
      len_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      iss_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      dat_we_q <= 1'b0;
      iss_q    <= 1'b0;
      rd_vld_q <= iss_q;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            len_q       <= data_length;
            ap_done_q   <= 1'b0;
            tlast_err_q <= 1'b0;
            ap_idle_q   <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            k_q         <= '0;
            state_q     <= INIT;
          end
        end
        INIT: begin
          dat_we_q    <= 1'b1;
          dat_addr_q  <= k_q;
          dat_wdata_q <= '0;
          if (k_q == LAST_TAP) begin
            k_q <= '0;
            if (len_q == '0) begin
              state_q <= DONE_ST;
            end else begin
              ss_tready_q <= 1'b1;
              state_q     <= WAIT_X;
            end
          end else begin
            k_q <= k_q + ADDR_W'(1);
          end
        end
        WAIT_X: begin
          if (ss_hs) begin
            ss_tready_q <= 1'b0;
            dat_we_q    <= 1'b1;
            dat_addr_q  <= wr_ptr_q;
            dat_wdata_q <= ss_tdata;
            k_q         <= '0;
            if (ss_tlast != is_last) begin
              tlast_err_q <= 1'b1;
            end
            state_q <= MAC;
          end
        end
        MAC: begin
          iss_q      <= 1'b1;
          tap_addr_q <= k_q;
          dat_addr_q <= rd_addr;
          if (k_q == LAST_TAP) begin
            k_q     <= '0;
            state_q <= DRAIN;
          end else begin
            k_q <= k_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Leave on the edge that folds in the final tap product.
          if (rd_vld_q && !iss_q) begin
            sm_tdata_q  <= mac_sum;
            sm_tvalid_q <= 1'b1;
            sm_tlast_q  <= is_last;
            wr_ptr_q    <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + ADDR_W'(1);
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (sm_tready) begin
            sm_tvalid_q <= 1'b0;
            sm_tlast_q  <= 1'b0;
            count_q     <= count_q + LEN_W'(1);
            if (count_q + LEN_W'(1) == len_q) begin
              state_q <= DONE_ST;
            end else begin
              ss_tready_q <= 1'b1;
              state_q     <= WAIT_X;
            end
          end
        end
        DONE_ST: begin
          ap_done_q <= 1'b1;
          ap_idle_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ap_idle   = ap_idle_q;
  assign ap_done   = ap_done_q;
  assign tlast_err = tlast_err_q;
  assign ss_tready = ss_tready_q;
  assign sm_tvalid = sm_tvalid_q;
  assign sm_tlast  = sm_tlast_q;
  assign sm_tdata  = sm_tdata_q;
  assign tap_addr  = tap_addr_q;
  assign dat_we    = dat_we_q;
  assign dat_addr  = dat_addr_q;
  assign dat_wdata = dat_wdata_q;

endmodule
